// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-enable divider, H/V counters, sync/blank decode
// and a pixel-tick delay line that lines sync/blank up with a downstream pixel pipeline.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE_DLY = 0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_tick,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic          video_on,
  output logic          h_sync,
  output logic          v_sync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] X_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] Y_LAST   = VW'(V_TOTAL - 1);
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [DW-1:0] r_divCnt;
  logic          r_pixTick;
  logic [HW-1:0] r_x;
  logic [VW-1:0] r_y;
  logic          r_lineStart;
  logic          r_frameStart;
  logic [2:0]    r_pipe [0:PIPE_DLY];

  logic          w_xWrap;
  logic          w_yWrap;
  logic [HW-1:0] w_nextX;
  logic [VW-1:0] w_nextY;
  logic          w_vis;
  logic          w_hs;
  logic          w_vs;

  // Divider: the tick is registered, so it lands one clk after the last count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_divCnt  <= '0;
      r_pixTick <= 1'b0;
    end else if (enable) begin
      r_pixTick <= (r_divCnt == DIV_LAST);
      r_divCnt  <= (r_divCnt == DIV_LAST) ? '0 : r_divCnt + 1'b1;
    end else begin
      r_pixTick <= 1'b0;
    end
  end

  assign w_xWrap = (r_x == X_LAST);
  assign w_yWrap = (r_y == Y_LAST);
  assign w_nextX = w_xWrap ? '0 : r_x + 1'b1;
  assign w_nextY = w_xWrap ? (w_yWrap ? '0 : r_y + 1'b1) : r_y;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x          <= '0;
      r_y          <= '0;
      r_lineStart  <= 1'b0;
      r_frameStart <= 1'b0;
    end else begin
      r_lineStart  <= r_pixTick && w_xWrap;
      r_frameStart <= r_pixTick && w_xWrap && w_yWrap;
      if (r_pixTick) begin
        r_x <= w_nextX;
        r_y <= w_nextY;
      end
    end
  end

  // Decode the coming counter values so stage 0 lines up with the counters.
  assign w_vis = (32'(w_nextX) < H_ACTIVE) && (32'(w_nextY) < V_ACTIVE);
  assign w_hs  = (32'(w_nextX) >= HS_START) && (32'(w_nextX) < HS_END);
  assign w_vs  = (32'(w_nextY) >= VS_START) && (32'(w_nextY) < VS_END);

  // Stages hold active-high {vis,hs,vs}; polarity is only applied at the outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= PIPE_DLY; i++) r_pipe[i] <= 3'b000;
    end else if (r_pixTick) begin
      r_pipe[0] <= {w_vis, w_hs, w_vs};
      for (int i = 1; i <= PIPE_DLY; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign pix_tick    = r_pixTick;
  assign pixel_x     = r_x;
  assign pixel_y     = r_y;
  assign line_start  = r_lineStart;
  assign frame_start = r_frameStart;
  assign video_on    = r_pipe[PIPE_DLY][2];
  assign h_sync      = r_pipe[PIPE_DLY][1] ? HS_POL : ~HS_POL;
  assign v_sync      = r_pipe[PIPE_DLY][0] ? VS_POL : ~VS_POL;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three differently configured instances on a small raster,
// randomized enable/reset, expectations from a tick-count model checked by a scoreboard.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HSY = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VSY = 2, VB = 2;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int NI = 3;
  localparam int NCYC = 8000;

  localparam int CDIV [NI] = '{4, 1, 3};
  localparam int PDLY [NI] = '{0, 2, 7};
  localparam bit HPOL [NI] = '{1'b0, 1'b1, 1'b1};
  localparam bit VPOL [NI] = '{1'b0, 1'b1, 1'b0};

  typedef struct packed {
    logic       tick;
    logic [7:0] x;
    logic [7:0] y;
    logic       vo;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } exp_t;
  typedef exp_t [NI-1:0] expset_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;

  logic       tk0, tk1, tk2, vo0, vo1, vo2, hs0, hs1, hs2;
  logic       vs0, vs1, vs2, ls0, ls1, ls2, fs0, fs1, fs2;
  logic [4:0] px0, px1, px2;
  logic [3:0] py0, py1, py2;

  int checks = 0;
  int failures = 0;

  expset_t sbq [$];

  int mCnt [NI];
  bit mTick [NI];
  int mP [NI];
  bit mLs [NI];
  bit mFs [NI];

  always #5 clk = ~clk;

  vga_timing_gen #(.CLK_DIV(CDIV[0]), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .HS_POL(HPOL[0]), .VS_POL(VPOL[0]),
    .PIPE_DLY(PDLY[0])) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .pix_tick(tk0), .pixel_x(px0), .pixel_y(py0),
    .video_on(vo0), .h_sync(hs0), .v_sync(vs0), .line_start(ls0), .frame_start(fs0));

  vga_timing_gen #(.CLK_DIV(CDIV[1]), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .HS_POL(HPOL[1]), .VS_POL(VPOL[1]),
    .PIPE_DLY(PDLY[1])) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .pix_tick(tk1), .pixel_x(px1), .pixel_y(py1),
    .video_on(vo1), .h_sync(hs1), .v_sync(vs1), .line_start(ls1), .frame_start(fs1));

  vga_timing_gen #(.CLK_DIV(CDIV[2]), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .HS_POL(HPOL[2]), .VS_POL(VPOL[2]),
    .PIPE_DLY(PDLY[2])) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .pix_tick(tk2), .pixel_x(px2), .pixel_y(py2),
    .video_on(vo2), .h_sync(hs2), .v_sync(vs2), .line_start(ls2), .frame_start(fs2));

  // The model only tracks how many pixel ticks happened since reset; the raster
  // position and every sync/blank level follow from that count with plain arithmetic.
  function automatic void modelReset();
    for (int i = 0; i < NI; i++) begin
      mCnt[i] = 0; mTick[i] = 1'b0; mP[i] = 0; mLs[i] = 1'b0; mFs[i] = 1'b0;
    end
  endfunction

  function automatic void modelStep(input bit en);
    for (int i = 0; i < NI; i++) begin
      if (mTick[i]) mP[i]++;
      mLs[i] = mTick[i] && (mP[i] % HT == 0);
      mFs[i] = mLs[i] && (mP[i] % (HT * VT) == 0);
      if (en) begin
        mTick[i] = (mCnt[i] == CDIV[i] - 1);
        mCnt[i]  = (mCnt[i] == CDIV[i] - 1) ? 0 : mCnt[i] + 1;
      end else begin
        mTick[i] = 1'b0;
      end
    end
  endfunction

  function automatic exp_t expectOf(input int i);
    exp_t e;
    int q, qx, qy;
    bit vis, hsA, vsA;
    e.tick = mTick[i];
    e.x    = 8'(mP[i] % HT);
    e.y    = 8'((mP[i] / HT) % VT);
    q = mP[i] - PDLY[i];
    vis = 1'b0; hsA = 1'b0; vsA = 1'b0;
    // Only pixels that were actually ticked after reset have entered the delay line.
    if (q >= 1) begin
      qx  = q % HT;
      qy  = (q / HT) % VT;
      vis = (qx < HA) && (qy < VA);
      hsA = (qx >= HA + HF) && (qx < HA + HF + HSY);
      vsA = (qy >= VA + VF) && (qy < VA + VF + VSY);
    end
    e.vo = vis;
    e.hs = hsA ? HPOL[i] : ~HPOL[i];
    e.vs = vsA ? VPOL[i] : ~VPOL[i];
    e.ls = mLs[i];
    e.fs = mFs[i];
    return e;
  endfunction

  function automatic void chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endfunction

  task automatic checkOutput(input int inst, input exp_t e, input logic tk, input logic [7:0] x,
                             input logic [7:0] y, input logic vo, input logic hs, input logic vs,
                             input logic ls, input logic fs);
    chk($sformatf("i%0d.pix_tick", inst),    {7'd0, tk}, {7'd0, e.tick});
    chk($sformatf("i%0d.pixel_x", inst),     x, e.x);
    chk($sformatf("i%0d.pixel_y", inst),     y, e.y);
    chk($sformatf("i%0d.video_on", inst),    {7'd0, vo}, {7'd0, e.vo});
    chk($sformatf("i%0d.h_sync", inst),      {7'd0, hs}, {7'd0, e.hs});
    chk($sformatf("i%0d.v_sync", inst),      {7'd0, vs}, {7'd0, e.vs});
    chk($sformatf("i%0d.line_start", inst),  {7'd0, ls}, {7'd0, e.ls});
    chk($sformatf("i%0d.frame_start", inst), {7'd0, fs}, {7'd0, e.fs});
  endtask

  // One clk per call: advance the model across the edge, then drive the next inputs.
  task automatic applyStimulus(input bit rst, input bit en);
    expset_t es;
    @(posedge clk);
    if (!reset) modelStep(enable);
    #2;
    reset  = rst;
    enable = en;
    if (rst) modelReset();
    for (int i = 0; i < NI; i++) es[i] = expectOf(i);
    sbq.push_back(es);
  endtask

  // Monitor: every output cycle is compared against the oldest queued expectation.
  initial begin
    expset_t es;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        es = sbq.pop_front();
        checkOutput(0, es[0], tk0, {3'd0, px0}, {4'd0, py0}, vo0, hs0, vs0, ls0, fs0);
        checkOutput(1, es[1], tk1, {3'd0, px1}, {4'd0, py1}, vo1, hs1, vs1, ls1, fs1);
        checkOutput(2, es[2], tk2, {3'd0, px2}, {4'd0, py2}, vo2, hs2, vs2, ls2, fs2);
      end
    end
  end

  initial begin
    int offLeft;
    int rstLeft;
    bit en;
    bit rst;
    offLeft = 0;
    rstLeft = 0;
    modelReset();
    repeat (3) applyStimulus(1'b1, 1'b0);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc == 4000) offLeft = 37;
      if (cyc == 6000) rstLeft = 2;
      if (cyc >= 5000 && rstLeft == 0 && $urandom_range(0, 1199) == 0)
        rstLeft = $urandom_range(1, 3);
      if (offLeft == 0 && $urandom_range(0, 99) < 4)
        offLeft = $urandom_range(1, 40);
      rst = (rstLeft > 0);
      if (rstLeft > 0) rstLeft--;
      en = (offLeft == 0);
      if (offLeft > 0) offLeft--;
      applyStimulus(rst, en);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 8'(sbq.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
